down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_pkg.sv | 12 +
 rtl/dn_count_reg.sv | 28 ++
 rtl/down_counter_timer.sv | 104 ++++++++++
 tb/tb_down_counter_timer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counter timer.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/dn_count_reg.sv
// WIDTH-bit count register with synchronous clear, load and a decrement
// that saturates at zero.
module dn_count_reg
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Down-counting timer: load/run/terminal-count FSM around dn_count_reg.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the last load after each terminal count.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_counter,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    timer_state_t     state;
    timer_state_t     next_state;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             terminal;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Only the auto-reload build needs to remember the last non-zero load.
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clock) begin
        if (reset_counter) begin
            reload_reg <= '0;
        end else if (load && (load_value != '0)) begin
            reload_reg <= load_value;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset_counter) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= terminal;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_load_value = load_value;
        cnt_dec        = 1'b0;
        terminal       = 1'b0;

        if (load) begin
            // Load beats enable and any terminal step; a zero load parks in IDLE.
            cnt_load   = 1'b1;
            next_state = (load_value != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                end
                RUN: begin
                    if (enable) begin
                        cnt_dec = 1'b1;
                        if (out == WIDTH'(1)) begin
                            terminal   = 1'b1;
                            next_state = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    cnt_load       = 1'b1;
                    cnt_load_value = reload_reg;
                    next_state     = RUN;
`else
                    next_state     = IDLE;
`endif
                end
                default: next_state = IDLE;
            endcase
        end
    end

    dn_count_reg #(
        .WIDTH (WIDTH)
    ) u_count (
        .clock      (clock),
        .clear      (reset_counter),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (out)
    );

    assign zero = (out == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH = 4).
module tb_down_counter_timer;

    logic       clock = 1'b0;
    logic       reset_counter;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic [3:0] out;
    logic       zero;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    down_counter_timer #(.WIDTH(4)) dut (
        .clock         (clock),
        .reset_counter (reset_counter),
        .load          (load),
        .load_value    (load_value),
        .enable        (enable),
        .out           (out),
        .zero          (zero),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input string tag, input int o, input int b, input int d);
        check({tag, ".out"}, 32'(out), 32'(o));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".zero"}, 32'(zero), 32'(o == 0));
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset_counter = 1'b1;
        load = 1'b0;
        load_value = 4'd0;
        enable = 1'b0;
        step();
        step();
        expect_all("reset", 0, 0, 0);
        reset_counter = 1'b0;

        // load 3, count to terminal
        enable = 1'b1;
        do_load(4'd3);
        expect_all("s27.load", 3, 1, 0);
        step(); expect_all("s27.c2", 2, 1, 0);
        step(); expect_all("s27.c1", 1, 1, 0);
        step(); expect_all("s27.c0", 0, 1, 1);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
        step(); expect_all("s27.idle", 0, 0, 0);
        step(); expect_all("s27.no_underflow", 0, 0, 0);

        // enable pattern 1,0,0,1
        do_load(4'd5);
        expect_all("s28.load", 5, 1, 0);
        enable = 1'b1; step(); expect_all("s28.e1", 4, 1, 0);
        enable = 1'b0; step(); expect_all("s28.e0a", 4, 1, 0);
        enable = 1'b0; step(); expect_all("s28.e0b", 4, 1, 0);
        enable = 1'b1; step(); expect_all("s28.e1b", 3, 1, 0);
        step(); step(); expect_all("s28.c1", 1, 1, 0);
        step(); expect_all("s28.c0", 0, 1, 1);
        step(); expect_all("s28.idle", 0, 0, 0);

        // zero load never runs or fires done
        do_load(4'd0);
        expect_all("s29.load0", 0, 0, 0);
        step(); expect_all("s29.after", 0, 0, 0);

        // zero load during RUN aborts to IDLE
        do_load(4'd4);
        do_load(4'd0);
        expect_all("abort0", 0, 0, 0);

        // load on the terminal step wins
        do_load(4'd2);
        expect_all("s30.load2", 2, 1, 0);
        step(); expect_all("s30.c1", 1, 1, 0);
        do_load(4'd9);
        expect_all("s30.reload9", 9, 1, 0);
        step(); expect_all("s30.c8", 8, 1, 0);

        // reset mid-count overrides load and enable
        step(); step(); expect_all("s31.c6", 6, 1, 0);
        reset_counter = 1'b1;
        load = 1'b1;
        load_value = 4'd5;
        step();
        expect_all("s31.reset", 0, 0, 0);
        reset_counter = 1'b0;
        load = 1'b0;
        step(); expect_all("s31.en_idle", 0, 0, 0);

        // full-range count from 15
        do_load(4'd15);
        expect_all("full.load", 15, 1, 0);
        for (int i = 14; i >= 1; i--) begin
            step();
            check("full.count", 32'(out), 32'(i));
            check("full.done_low", 32'(done), 32'd0);
        end
        step(); expect_all("full.c0", 0, 1, 1);
        step(); expect_all("full.idle", 0, 0, 0);
`else
        // auto reload: 3 restarts, then load 2 gives 2,1,0,2,1,0
        step(); expect_all("ar.reload3", 3, 1, 0);
        do_load(4'd2);
        expect_all("s32.l2", 2, 1, 0);
        step(); expect_all("s32.c1", 1, 1, 0);
        step(); expect_all("s32.c0", 0, 1, 1);
        step(); expect_all("s32.r2", 2, 1, 0);
        step(); expect_all("s32.r1", 1, 1, 0);
        step(); expect_all("s32.r0", 0, 1, 1);
        step(); expect_all("s32.rr2", 2, 1, 0);
        reset_counter = 1'b1;
        step(); expect_all("ar.reset", 0, 0, 0);
        reset_counter = 1'b0;
        step(); expect_all("ar.idle", 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
